fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC, issues word-addressed reads to instruction memory over a valid/ready handshake, and buffers returned words in a small fetch queue. It presents one instruction and its PC+1 per cycle to IF/ID, honouring the hazard stall, redirects from later stages (branch/call/return) and halt.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_queue.sv | 95 +++++++++
 rtl/fetch_stage.sv | 149 ++++++++++++++
 tb/tb_fetch_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and its queue.
//   inst_t        : 16-bit instruction word
//   pc_t          : 16-bit word address
//   NOP_INST      : word presented when no real instruction is available
//   fetch_state_e : fetch controller state
package cpu_pkg;

  typedef logic [15:0] inst_t;
  typedef logic [15:0] pc_t;

  localparam inst_t NOP_INST = 16'hF000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of {instruction, PC+1} entries feeding the IF/ID register.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   flush                 : empty the queue (wins over push/pop)
//   push, push_inst/pc    : write one entry at the tail
//   pop                   : retire the head entry
//   head_valid/inst/pc    : combinational view of the head entry
//   count                 : current occupancy (0..QDEPTH)
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  inst_t         push_inst,
  input  pc_t           push_pc,
  input  logic          pop,
  output logic          head_valid,
  output inst_t         head_inst,
  output pc_t           head_pc,
  output logic [CW-1:0] count
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef struct packed {
    inst_t inst;
    pc_t   pc;
  } entry_t;

  entry_t        mem_q [QDEPTH];
  entry_t        mem_d [QDEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(QDEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CW'(QDEPTH)) || pop_ok);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = '{inst: push_inst, pc: push_pc};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CW'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_inst  = mem_q[rd_ptr_q].inst;
  assign head_pc    = mem_q[rd_ptr_q].pc;
  assign count      = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage in front of the IF/ID register. Owns the PC,
// issues word reads over a valid/ready handshake, buffers returned words
// and presents one instruction (with its PC+1) per cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   RUN    | fetching; requests issued while credit remains
//   HALTED | HLT seen; no requests, in-flight data drained and dropped
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   hazard              : IF/ID stall, head is held
//   redirect/_pc        : flush and refetch from redirect_pc
//   halt                : stop fetching permanently (until reset)
//   imem_req/addr/rdy   : request channel (accepted on req && rdy)
//   imem_rvalid/rdata   : in-order read data
//   instruction/PC_out  : to IF/ID; inst_valid marks a real instruction
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int    QDEPTH   = 2,
  parameter pc_t   RESET_PC = 16'h0000,
  parameter inst_t NOP_INST = 16'hF000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  hazard,
  input  logic  redirect,
  input  pc_t   redirect_pc,
  input  logic  halt,
  output logic  imem_req,
  output pc_t   imem_addr,
  input  logic  imem_rdy,
  input  logic  imem_rvalid,
  input  inst_t imem_rdata,
  output inst_t instruction,
  output pc_t   PC_out,
  output logic  inst_valid
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_e  state_q, state_d;
  pc_t           pc_q, pc_d;
  pc_t           resp_pc_q, resp_pc_d;
  pc_t           pc_out_q, pc_out_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          q_head_valid;
  inst_t         q_head_inst;
  pc_t           q_head_pc;
  logic [CW-1:0] q_count;

  logic          running;
  logic          fetch_en;
  logic          flush;
  logic          pop;
  logic          push;
  logic          accept;
  logic [CW:0]   credit_used;

  always_comb begin
    // rst_n gates the request so nothing is asserted while in reset.
    running  = rst_n && (state_q == RUN);
    fetch_en = running && !halt && !redirect;
    flush    = running && (halt || redirect);

    inst_valid  = fetch_en && q_head_valid;
    instruction = inst_valid ? q_head_inst : NOP_INST;
    PC_out      = inst_valid ? q_head_pc : pc_out_q;
    pop         = inst_valid && !hazard;

    // Credit counts the slot freed by this cycle's pop so a 1-cycle memory
    // sustains one instruction per cycle with only QDEPTH entries.
    credit_used = (CW+1)'(outst_q) + (CW+1)'(q_count) - (CW+1)'(pop);
    imem_req    = fetch_en && (credit_used < (CW+1)'(QDEPTH));
    imem_addr   = pc_q;
    accept      = imem_req && imem_rdy;

    push = imem_rvalid && fetch_en && (drop_q == '0);

    state_d   = state_q;
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    pc_out_d  = PC_out;
    outst_d   = outst_q + CW'(accept) - CW'(imem_rvalid);
    drop_d    = drop_q;

    if (flush) begin
      // Everything still in flight is stale; a response landing this
      // cycle is discarded by the flush itself.
      drop_d = outst_q - CW'(imem_rvalid);
    end else if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end

    if (running && halt) begin
      state_d = HALTED;
    end else if (running && redirect) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
    end else begin
      if (accept) begin
        pc_d = pc_q + 16'd1;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 16'd1;
      end
    end
  end

  // resp_pc_q is the address of the next response that will be kept, so
  // each pushed entry carries the PC+1 of the word it holds.
  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_inst (imem_rdata),
    .push_pc   (resp_pc_q + 16'd1),
    .pop       (pop),
    .head_valid(q_head_valid),
    .head_inst (q_head_inst),
    .head_pc   (q_head_pc),
    .count     (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      pc_out_q  <= RESET_PC + 16'd1;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      pc_out_q  <= pc_out_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// phase, all compared against an address-stream reference model.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hazard = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [15:0] instruction;
  logic [15:0] PC_out;
  logic        inst_valid;

  always #5 clk = ~clk;

  fetch_stage #(
    .QDEPTH  (QD),
    .RESET_PC(16'h0000),
    .NOP_INST(16'hF000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hazard     (hazard),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .PC_out     (PC_out),
    .inst_valid (inst_valid)
  );

  typedef struct {
    logic [15:0] addr;
    int          ready;
    bit          stale;
  } req_t;

  logic [15:0] mem [65536];
  req_t        pend [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc;
  int          lat;
  int          last_ready;
  bit          rand_lat;
  bit          halted_m;
  int          q_model;
  logic [15:0] fetch_addr;
  logic [15:0] exp_addr;
  logic [15:0] last_pc_out;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    hazard      = 1'b0;
    redirect    = 1'b0;
    halt        = 1'b0;
    redirect_pc = 16'h0000;
    imem_rdy    = 1'b1;
    imem_rvalid = 1'b0;
    pend.delete();
    #1;
    chk1 ("rst_imem_req",    imem_req,    1'b0);
    chk16("rst_imem_addr",   imem_addr,   16'h0000);
    chk16("rst_instruction", instruction, 16'hF000);
    chk16("rst_pc_out",      PC_out,      16'h0001);
    chk1 ("rst_inst_valid",  inst_valid,  1'b0);
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    cyc         = 0;
    last_ready  = -1;
    q_model     = 0;
    halted_m    = 1'b0;
    fetch_addr  = 16'h0000;
    exp_addr    = 16'h0000;
    last_pc_out = 16'h0001;
  endtask

  // One clock cycle: drive memory response, check outputs against the
  // model, advance the model at the rising edge. Entered and left at negedge.
  task automatic step();
    bit   blocked, exp_valid, consume, exp_req;
    int   l, rdy_at;
    req_t e;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem[pend[0].addr];
    end
    #1;
    blocked   = halted_m || halt || redirect;
    exp_valid = !blocked && (q_model > 0);
    consume   = exp_valid && !hazard;
    exp_req   = !blocked && ((pend.size() + q_model - (consume ? 1 : 0)) < QD);

    chk1("inst_valid", inst_valid, exp_valid);
    if (exp_valid) begin
      chk16("instruction", instruction, mem[exp_addr]);
      chk16("pc_out", PC_out, exp_addr + 16'd1);
    end else begin
      chk16("nop_instruction", instruction, 16'hF000);
      chk16("held_pc_out", PC_out, last_pc_out);
    end
    chk1("imem_req", imem_req, exp_req);
    if (exp_req) chk16("imem_addr", imem_addr, fetch_addr);

    @(posedge clk);
    if ((halt || redirect) && !halted_m) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      q_model = 0;
    end
    if (imem_rvalid) begin
      e = pend.pop_front();
      if (!e.stale) q_model++;
    end
    if (exp_valid) last_pc_out = exp_addr + 16'd1;
    if (consume) begin
      q_model--;
      exp_addr = exp_addr + 16'd1;
    end
    if (exp_req && imem_rdy) begin
      l = rand_lat ? int'($urandom_range(1, 3)) : lat;
      rdy_at = cyc + l;
      if (rdy_at <= last_ready) rdy_at = last_ready + 1;
      last_ready = rdy_at;
      pend.push_back('{addr: fetch_addr, ready: rdy_at, stale: 1'b0});
      fetch_addr = fetch_addr + 16'd1;
    end
    if (!halted_m) begin
      if (halt) begin
        halted_m = 1'b1;
      end else if (redirect) begin
        fetch_addr = redirect_pc;
        exp_addr   = redirect_pc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] first_tab [4];
    logic [15:0] req_seen [2];
    int          n_req;
    bit          found;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456; mem[3] = 16'h4567;
    first_tab[0] = 16'h1234; first_tab[1] = 16'h2345;
    first_tab[2] = 16'h3456; first_tab[3] = 16'h4567;
    rand_lat = 1'b0;
    lat      = 1;
    #2;

    // Back-to-back fetch at 1-cycle latency.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 4) begin
        chk1 ("t1_req", imem_req, 1'b1);
        chk16("t1_addr", imem_addr, 16'(k));
      end
      if (k >= 2) begin
        chk1 ("t1_valid", inst_valid, 1'b1);
        chk16("t1_inst", instruction, first_tab[k-2]);
        chk16("t1_pc_out", PC_out, 16'(k - 1));
      end
      step();
    end

    // Hazard holds the head at 2345.
    do_reset();
    repeat (3) step();
    hazard = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk16("t2_hold_inst", instruction, 16'h2345);
      chk16("t2_hold_pc", PC_out, 16'h0002);
      step();
    end
    hazard = 1'b0;
    step();
    #1;
    chk16("t2_resume_inst", instruction, 16'h3456);
    chk16("t2_resume_pc", PC_out, 16'h0003);
    repeat (4) step();

    // Redirect with two requests outstanding at 2-cycle latency.
    lat = 2;
    do_reset();
    for (int i = 0; i < 10 && pend.size() < 2; i++) step();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    chk1("t3_redir_valid", inst_valid, 1'b0);
    chk1("t3_redir_req", imem_req, 1'b0);
    step();
    redirect = 1'b0;
    found = 1'b0;
    n_req = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (imem_req && n_req == 0) begin
        chk16("t3_first_addr", imem_addr, 16'h0040);
        n_req = 1;
      end
      if (inst_valid) begin
        chk16("t3_first_inst", instruction, mem[16'h0040]);
        chk16("t3_first_pc", PC_out, 16'h0041);
        found = 1'b1;
      end
      step();
    end
    chk1("t3_first_valid_seen", found, 1'b1);

    // Memory not ready for 4 cycles.
    lat = 1;
    do_reset();
    repeat (4) step();
    imem_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1 ("t4_req_held", imem_req, 1'b1);
      chk16("t4_addr_stable", imem_addr, 16'h0004);
      if (k == 3) chk1("t4_drained", inst_valid, 1'b0);
      step();
    end
    imem_rdy = 1'b1;
    repeat (6) step();

    // Halt is permanent; redirect ignored; reset restarts.
    lat = 2;
    do_reset();
    repeat (5) step();
    halt = 1'b1;
    #1;
    chk1 ("t5_halt_req", imem_req, 1'b0);
    chk1 ("t5_halt_valid", inst_valid, 1'b0);
    chk16("t5_halt_inst", instruction, 16'hF000);
    step();
    halt = 1'b0;
    for (int k = 0; k < 8; k++) begin
      redirect    = 1'($urandom_range(0, 1));
      redirect_pc = 16'h0100;
      #1;
      chk1 ("t5_halted_req", imem_req, 1'b0);
      chk1 ("t5_halted_valid", inst_valid, 1'b0);
      chk16("t5_halted_inst", instruction, 16'hF000);
      step();
    end
    redirect = 1'b0;
    do_reset();
    #1;
    chk1 ("t5_restart_req", imem_req, 1'b1);
    chk16("t5_restart_addr", imem_addr, 16'h0000);
    repeat (4) step();

    // PC wrap at 16'hFFFF.
    lat = 1;
    do_reset();
    repeat (2) step();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    req_seen[0] = 16'hDEAD;
    req_seen[1] = 16'hDEAD;
    n_req = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (imem_req && imem_rdy && n_req < 2) begin
        req_seen[n_req] = imem_addr;
        n_req++;
      end
      if (inst_valid) begin
        chk16("t6_wrap_inst", instruction, mem[16'hFFFF]);
        chk16("t6_wrap_pc_out", PC_out, 16'h0000);
        found = 1'b1;
      end
      step();
    end
    chk1 ("t6_wrap_seen", found, 1'b1);
    chk16("t6_first_addr", req_seen[0], 16'hFFFF);
    chk16("t6_next_addr", req_seen[1], 16'h0000);
    repeat (3) step();

    // Randomized traffic: ready, latency, hazard and redirect.
    rand_lat = 1'b1;
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      imem_rdy    = ($urandom_range(0, 3) != 0);
      hazard      = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 63) == 0);
      redirect_pc = 16'($urandom);
      step();
    end
    hazard   = 1'b0;
    redirect = 1'b0;
    imem_rdy = 1'b1;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
